// File: rtl/poserror_streamer.sv
// Position-error stream transmitter: on trig, replays N buffered floats as a
// valid/ready stream with Ut DPRAM read address/enable issued one cycle ahead.
module poserror_streamer #(
    parameter int    ADDR_W = 9,
    parameter string DEBUG  = "false"
) (
    input  logic              sysClk,
    input  logic              Reset,
    input  logic              trig,
    input  logic [9:0]        num_elem,
    input  logic              pos_wren,
    input  logic [ADDR_W-1:0] pos_wraddr,
    input  logic [31:0]       pos_wrdata,
    input  logic              posError_tready,
    input  logic              overrun_clr,
    output logic [31:0]       fposError,
    output logic              posError_tvalid,
    output logic              posError_tlast,
    output logic              s_ut_tvalid_t,
    output logic [ADDR_W-1:0] ut_ramRdAddr,
    output logic              ut_outValid,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [31:0]       frame_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NW    = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    (* mark_debug = DEBUG *) state_t state_q;
    (* mark_debug = DEBUG *) logic [ADDR_W-1:0] addr_q;
    (* mark_debug = DEBUG *) logic tvalid_q;
    (* mark_debug = DEBUG *) logic tlast_q;
    (* mark_debug = DEBUG *) logic [31:0] rdata_q;
    logic [NW-1:0] n_q;
    logic          done_q;
    logic          overrun_q;
    logic [31:0]   fcnt_q;

    logic [31:0]   mem_q [DEPTH];
    logic          adv;
    logic          addr_is_last;
    logic [NW-1:0] n_clamp;

    assign adv          = !tvalid_q || posError_tready;
    assign addr_is_last = (NW'(addr_q) == (n_q - NW'(1)));

    always_comb begin
        n_clamp = NW'(num_elem);
        if (int'(num_elem) > DEPTH) n_clamp = NW'(DEPTH);
    end

    // Read-first buffer; read output only moves on adv so data holds under stall.
    always_ff @(posedge sysClk) begin
        if (pos_wren) mem_q[pos_wraddr] <= pos_wrdata;
    end

    always_ff @(posedge sysClk) begin
        if (Reset)    rdata_q <= '0;
        else if (adv) rdata_q <= mem_q[addr_q];
    end

    always_ff @(posedge sysClk) begin
        if (Reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            n_q       <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (adv) begin
                tvalid_q <= (state_q == RUN);
                tlast_q  <= (state_q == RUN) && addr_is_last;
            end
            if (trig && state_q != IDLE) overrun_q <= 1'b1;
            else if (overrun_clr)        overrun_q <= 1'b0;
            case (state_q)
                IDLE: if (trig) begin
                    if (n_clamp != '0) begin
                        state_q <= RUN;
                        addr_q  <= '0;
                        n_q     <= n_clamp;
                    end else begin
                        done_q <= 1'b1;
                        fcnt_q <= fcnt_q + 32'd1;
                    end
                end
                RUN: if (adv) begin
                    // Hold the last address rather than wrapping to 0.
                    if (addr_is_last) state_q <= DRAIN;
                    else              addr_q  <= addr_q + 1'b1;
                end
                DRAIN: if (tvalid_q && posError_tready && tlast_q) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    fcnt_q  <= fcnt_q + 32'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fposError       = rdata_q;
    assign posError_tvalid = tvalid_q;
    assign posError_tlast  = tlast_q;
    assign s_ut_tvalid_t   = tvalid_q;
    assign ut_ramRdAddr    = addr_q;
    assign ut_outValid     = (state_q == RUN) && adv;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign overrun         = overrun_q;
    assign frame_count     = fcnt_q;
endmodule

// File: doc/poserror_streamer.md
Name: poserror_streamer

Overview:
- Transmit end of the position-error stream consumed by the Ut eigen-projection path.
- On each trig, reads N floating-point position errors from an internal buffer and emits them as a stream (fposError, posError_tvalid, posError_tlast).
- Drives ut_ramRdAddr and ut_outValid one cycle ahead of the data, so Ut DPRAM output and s_ut_tvalid_t line up beat-for-beat with the position-error beats.
- Honours backpressure from the multiplier's a-channel tready.

Parameters:
- ADDR_W, 9, buffer/Ut address width (depth 2**ADDR_W = 512).
- DEBUG, "false", mark_debug attribute value applied to stream and FSM signals.

Ports:
- sysClk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- trig  in  1  single-cycle frame start
- num_elem  in  10  elements per frame; latched at start; 0 = empty frame; values >512 clamp to 512
- pos_wren  in  1  buffer write enable (host/BPM side)
- pos_wraddr  in  9  buffer write address
- pos_wrdata  in  32  buffer write data (IEEE-754 single)
- posError_tready  in  1  downstream ready
- overrun_clr  in  1  clears overrun
- fposError  out  32  stream data
- posError_tvalid  out  1  stream valid
- posError_tlast  out  1  final beat of frame
- s_ut_tvalid_t  out  1  equal to posError_tvalid (Ut b-channel valid)
- ut_ramRdAddr  out  9  Ut DPRAM port-B address
- ut_outValid  out  1  Ut DPRAM port-B enable
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- overrun  out  1  sticky: trig arrived while busy
- frame_count  out  32  completed frames, wraps modulo 2^32

Behaviour:
- Reset:
  - All outputs 0; FSM goes to IDLE; address counter 0; overrun 0; frame_count 0.
  - Buffer contents are not cleared.
  - Reset mid-frame aborts the frame immediately; no tlast and no done.
- Buffer:
  - 512x32 simple dual-port, 1-cycle read latency, read-first on address collision.
  - Read enable = adv. When adv is low the read output holds.
- Pipeline:
  - adv = !posError_tvalid | posError_tready.
  - Address stage is valid when state==RUN.
  - On adv: posError_tvalid <= (state==RUN); posError_tlast <= (state==RUN) & (addr==N-1).
- Ut alignment:
  - ut_outValid = (state==RUN) & adv.
  - ut_ramRdAddr = addr.
  - Because the Ut DPRAM port-B output holds while enb is low, it stays aligned with fposError under stalls.
- FSM:
  - IDLE: busy=0.
    - trig & N!=0 → RUN, with addr=0 and N latched.
    - trig & N==0 → done pulse next cycle, frame_count+1, stay IDLE.
  - RUN: busy=1. On adv, addr increments. When addr==N-1 issues on adv → DRAIN.
  - DRAIN: busy=1. When the tlast beat is accepted (tvalid & tready & tlast) → IDLE, done=1 next cycle, frame_count+1.
- Latency with tready=1 and trig at cycle T:
  - RUN from T+1; first address at T+1.
  - First tvalid at T+2.
  - N contiguous beats at T+2..T+N+1; tlast at T+N+1.
  - done at T+N+2; busy high T+1..T+N+1.
- Stalls:
  - tvalid, data and tlast must stay stable while tvalid & !tready.
  - No address advance and no ut_outValid during a stall.
- trig while busy: ignored; overrun <= 1. trig in the done cycle is accepted (state is IDLE).
- overrun_clr and trig-while-busy in the same cycle: set wins.
- Writes during a frame are permitted. Same-address same-cycle collision returns old data.

Test Plan:
- Write buffer[i] = float(i) for i=0..7; num_elem=8; trig; tready=1 → beats at T+2..T+9 with data 0.0..7.0; tlast at T+9; ut_ramRdAddr 0..7 with ut_outValid at T+1..T+8; done at T+10; frame_count=1.
- Same frame, tready low for 3 cycles starting at beat 3 → beat 3 (3.0) held stable 4 cycles; no ut_outValid during the stall; all 8 beats in order, none duplicated.
- num_elem=0, trig → no tvalid; done pulse at T+1; frame_count increments.
- num_elem=600 → exactly 512 beats; tlast on addr 511; no wrap to addr 0.
- Second trig at T+4 of an 8-beat frame → frame unaffected; overrun=1 until overrun_clr; trig in the done cycle starts a new frame.
- Assert Reset at beat 5 → tvalid=0 next cycle; busy=0; no done; next trig restarts from addr 0.
